// File: rtl/morse_key_encoder.sv
// ============================================================================
// morse_key_encoder: turns P1 key presses into 2-bit Morse symbols, packs them
// into letter words and strobes each finished word into the game RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module morse_key_encoder #(
  parameter int DASH_TICKS = 3,
  parameter int MAX_TICKS  = 7,
  parameter int SLOTS      = 5,
  parameter int DEPTH      = 16
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic                         tick_i,
  input  logic                         key_n_i,
  input  logic                         next_n_i,
  input  logic                         done_n_i,
  output logic [2*SLOTS-1:0]           q_o,
  output logic                         write_o,
  output logic [$clog2(DEPTH)-1:0]     addr_o,
  output logic [$clog2(SLOTS+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         finished_o
);

  localparam int QW = 2 * SLOTS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int DW = $clog2(MAX_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_COMMIT  = 3'd2,
    S_HOLD    = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q;
  logic [2:0]    meta_q, sync_q, prev_q;
  logic [2:0]    act, edg;
  logic [QW-1:0] q_q;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] dur_q, dur_d;
  logic [1:0]    sym_d;
  logic          write_q, full_q, finished_q, commit_pend_q, done_pend_q;

  // Bit order in the synchroniser: {done, next, key}; inverted to active-high.
  assign act = ~sync_q;
  assign edg = act & ~prev_q;

  // A tick arriving with the release is counted before the symbol is chosen.
  always_comb begin
    dur_d = dur_q;
    if (tick_i && enable_i && (dur_q != DW'(MAX_TICKS))) begin
      dur_d = dur_q + DW'(1);
    end
    sym_d = (dur_d >= DW'(DASH_TICKS)) ? 2'b11 : 2'b01;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q        <= 3'b111;
      sync_q        <= 3'b111;
      prev_q        <= 3'b000;
      state_q       <= S_IDLE;
      q_q           <= '0;
      addr_q        <= '0;
      count_q       <= '0;
      dur_q         <= '0;
      write_q       <= 1'b0;
      full_q        <= 1'b0;
      finished_q    <= 1'b0;
      commit_pend_q <= 1'b0;
      done_pend_q   <= 1'b0;
    end else begin
      meta_q <= {done_n_i, next_n_i, key_n_i};
      sync_q <= meta_q;
      prev_q <= act;
      case (state_q)
        S_IDLE, S_PRESS: begin
          if (!enable_i) begin
            state_q <= S_IDLE;
          end else if (edg[2]) begin
            if (count_q != '0) begin
              state_q     <= S_COMMIT;
              write_q     <= 1'b1;
              done_pend_q <= 1'b1;
            end else begin
              state_q    <= S_DONE;
              finished_q <= 1'b1;
            end
          end else if (state_q == S_PRESS) begin
            if (!act[0]) begin
              q_q           <= {q_q[QW-3:0], sym_d};
              count_q       <= count_q + CW'(1);
              commit_pend_q <= edg[1];
              state_q       <= S_IDLE;
            end else begin
              dur_q <= dur_d;
            end
          end else if ((count_q == CW'(SLOTS)) || commit_pend_q ||
                       (edg[1] && (count_q != '0) && !full_q)) begin
            // q last changed at least one cycle ago, so write may rise now.
            state_q <= S_COMMIT;
            write_q <= 1'b1;
          end else if (edg[0] && !full_q) begin
            state_q <= S_PRESS;
            dur_q   <= '0;
          end
        end
        S_COMMIT: begin
          write_q <= 1'b0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          state_q <= S_ADVANCE;
        end
        S_ADVANCE: begin
          q_q           <= '0;
          count_q       <= '0;
          commit_pend_q <= 1'b0;
          if (addr_q == AW'(DEPTH - 1)) begin
            full_q <= 1'b1;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
          if (done_pend_q) begin
            state_q    <= S_DONE;
            finished_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_DONE;
        end
      endcase
    end
  end

  assign q_o        = q_q;
  assign write_o    = write_q;
  assign addr_o     = addr_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign finished_o = finished_q;

endmodule

`default_nettype wire

// File: tb/tb_morse_key_encoder.sv
// ============================================================================
// tb_morse_key_encoder: directed stimulus with a write-strobe scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_morse_key_encoder;

  logic       clk = 1'b0;
  logic       rst, enable, tick, key_n, next_n, done_n;
  logic [9:0] q;
  logic       write;
  logic [3:0] addr;
  logic [2:0] count;
  logic       full, finished;

  typedef struct {
    logic [3:0] a;
    logic [9:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  logic [9:0] prev_q    = '0;
  logic [3:0] prev_addr = '0;
  logic       prev_wr   = 1'b0;

  always #5 clk = ~clk;

  morse_key_encoder #(
    .DASH_TICKS(3), .MAX_TICKS(7), .SLOTS(5), .DEPTH(16)
  ) dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .enable_i  (enable),
    .tick_i    (tick),
    .key_n_i   (key_n),
    .next_n_i  (next_n),
    .done_n_i  (done_n),
    .q_o       (q),
    .write_o   (write),
    .addr_o    (addr),
    .count_o   (count),
    .full_o    (full),
    .finished_o(finished)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int d);
    exp_t e;
    e.a = 4'(a);
    e.d = 10'(d);
    sb.push_back(e);
  endtask

  // Hold the key for n ticks; n = 0 releases before any tick.
  task automatic press(input int n);
    key_n = 1'b0;
    cyc(4);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
    key_n = 1'b1;
    cyc(4);
  endtask

  task automatic press_next();
    next_n = 1'b0;
    cyc(2);
    next_n = 1'b1;
    cyc(8);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q"}, 32'(q), 0);
    chk({tag, "_write"}, 32'(write), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_finished"}, 32'(finished), 0);
  endtask

  // Monitor: every write cycle pops one expected (addr, word) pair.
  always @(negedge clk) begin
    if (write) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got write at addr %0d q 0x%0h, expected none", addr, q);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(addr), 32'(e.a));
        chk("wr_q", 32'(q), 32'(e.d));
      end
      if (!prev_wr) begin
        chk("setup_q_stable", 32'(q), 32'(prev_q));
        chk("setup_addr_stable", 32'(addr), 32'(prev_addr));
      end
    end
    prev_q    <= q;
    prev_addr <= addr;
    prev_wr   <= write;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; tick = 1'b0;
    key_n = 1'b1; next_n = 1'b1; done_n = 1'b1;
    cyc(3);
    chk_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Single short press then next.
    press(1);
    chk("dot_count", 32'(count), 1);
    chk("dot_q", 32'(q), 32'h001);
    push(0, 10'b00_0000_0001);
    press_next();
    chk("adv1_addr", 32'(addr), 1);
    chk("adv1_q", 32'(q), 0);
    chk("adv1_count", 32'(count), 0);

    // Dash, dot, saturated dash.
    press(3);
    press(1);
    press(9);
    chk("dds_count", 32'(count), 3);
    chk("dds_q", 32'(q), 32'b00_0011_0111);
    push(1, 10'b00_0011_0111);
    press_next();
    chk("adv2_addr", 32'(addr), 2);

    // Five zero-duration dots auto-commit.
    for (int i = 0; i < 4; i++) press(0);
    chk("four_q", 32'(q), 32'b00_0101_0101);
    push(2, 10'b01_0101_0101);
    press(0);
    cyc(6);
    chk("auto_addr", 32'(addr), 3);
    chk("auto_count", 32'(count), 0);

    // Enable dropped mid-press discards the symbol.
    press(1);
    key_n = 1'b0;
    cyc(4);
    tick = 1'b1; cyc(1); tick = 1'b0;
    enable = 1'b0;
    cyc(2);
    key_n = 1'b1;
    cyc(4);
    chk("abort_count", 32'(count), 1);
    chk("abort_q", 32'(q), 32'h001);
    enable = 1'b1;
    cyc(2);
    push(3, 10'h001);
    press_next();
    chk("adv4_addr", 32'(addr), 4);

    // next and done in the same cycle: one commit, then finished.
    press(4);
    push(4, 10'h003);
    next_n = 1'b0; done_n = 1'b0;
    cyc(2);
    next_n = 1'b1; done_n = 1'b1;
    cyc(8);
    chk("nd_finished", 32'(finished), 1);
    chk("nd_addr", 32'(addr), 5);
    press(1);
    press_next();
    chk("done_ignore_count", 32'(count), 0);
    chk("done_ignore_q", 32'(q), 0);
    chk("done_ignore_addr", 32'(addr), 5);

    // Reset during HOLD: the already-issued write stands, nothing after.
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(2);
    chk_zero("rst2");
    press(1);
    push(0, 10'h001);
    next_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_write", 32'(write), 0);
    chk("hold_q", 32'(q), 32'h001);
    rst = 1'b1;
    next_n = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk_zero("rst_hold");

    // Fill all 16 words, then a 17th letter is ignored.
    for (int i = 0; i < 16; i++) begin
      press(0);
      push(i, 10'h001);
      press_next();
    end
    chk("full_flag", 32'(full), 1);
    chk("full_addr", 32'(addr), 15);
    press(1);
    chk("full_ignore_count", 32'(count), 0);
    press_next();
    chk("full_addr_hold", 32'(addr), 15);
    done_n = 1'b0;
    cyc(2);
    done_n = 1'b1;
    cyc(4);
    chk("full_finished", 32'(finished), 1);

    cyc(4);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
